fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the pipelined core. Owns the PC, issues requests to a variable-latency

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its surroundings.
//   master : the fetch controller (drives the imem request and the decode-side outputs)
//   slave  : the environment (instruction memory, decode stage, execute redirect)
// Handshakes: imem request completes on imem_req && imem_gnt; decode transfer
// completes on InstrValid && InstrReady; imem_rvalid carries no back-pressure.
interface fetch_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     Redirect;
    logic [ADDRESS_WIDTH-1:0] RedirectPC;
    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [DATA_WIDTH-1:0]    imem_rdata;
    logic                     InstrValid;
    logic [DATA_WIDTH-1:0]    Instr;
    logic [ADDRESS_WIDTH-1:0] InstrPC;
    logic [DATA_WIDTH-1:0]    PCPlus4;
    logic                     InstrReady;

    modport master (
        input  Redirect, RedirectPC, imem_gnt, imem_rvalid, imem_rdata, InstrReady,
        output imem_req, imem_addr, InstrValid, Instr, InstrPC, PCPlus4
    );

    modport slave (
        output Redirect, RedirectPC, imem_gnt, imem_rvalid, imem_rdata, InstrReady,
        input  imem_req, imem_addr, InstrValid, Instr, InstrPC, PCPlus4
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues requests to a variable-latency
// instruction memory and buffers returned words in an in-order FIFO toward decode.
// A redirect flushes the buffer and marks every outstanding response as stale.
//
// Handshake semantics (all transfers happen at the rising clock edge):
//   imem request : accepted when imem_req && imem_gnt; imem_addr holds while req && !gnt.
//   imem response: imem_rvalid is unconditional, one per grant, in grant order.
//   decode       : head word moves when InstrValid && InstrReady; InstrValid never
//                  depends on InstrReady.
//
// Optional build macro: FETCH_PERF_EN adds the FetchBubbles / RedirectCount counters.
module fetch_ctrl #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter int                       FIFO_DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    fetch_ctrl_if.master        bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         FetchBubbles,
    output logic [31:0]         RedirectCount
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    // Fetch state
    logic [ADDRESS_WIDTH-1:0] pc;
    ptr_t                     wr_ptr;       // next entry to allocate at grant
    ptr_t                     fill_ptr;     // oldest allocated entry still awaiting data
    ptr_t                     rd_ptr;       // FIFO head toward decode
    cnt_t                     alloc_cnt;    // allocated entries (filled or not)
    cnt_t                     inflight_cnt; // granted responses not yet returned
    cnt_t                     drop_cnt;     // outstanding responses known to be stale
    logic [FIFO_DEPTH-1:0]    filled;

    logic [ADDRESS_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];

    // Cycle events
    logic                     req;
    logic                     grant;
    logic                     rsp;
    logic                     rsp_drop;
    logic                     fill;
    logic                     head_valid;
    logic                     pop;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic [ADDRESS_WIDTH-1:0] head_pc;

    // Request depends only on registered counters plus rst/Redirect.
    assign req         = !rst && !bus.Redirect && (alloc_cnt < DEPTH_C) && (inflight_cnt < DEPTH_C);
    assign grant       = req && bus.imem_gnt;
    // A response with nothing outstanding (e.g. left over from before reset) is ignored.
    assign rsp         = bus.imem_rvalid && (inflight_cnt != '0);
    assign rsp_drop    = rsp && (drop_cnt != '0);
    // A response landing in a redirect cycle belongs to the old stream and is discarded.
    assign fill        = rsp && (drop_cnt == '0) && !bus.Redirect;
    assign head_valid  = !rst && !bus.Redirect && (alloc_cnt != '0) && filled[rd_ptr];
    assign pop         = head_valid && bus.InstrReady;
    assign redirect_pc = bus.RedirectPC & ~ADDRESS_WIDTH'(3);
    assign head_pc     = pc_mem[rd_ptr];

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc;
    assign bus.InstrValid = head_valid;
    assign bus.Instr      = data_mem[rd_ptr];
    assign bus.InstrPC    = head_pc;
    assign bus.PCPlus4    = DATA_WIDTH'(head_pc + ADDRESS_WIDTH'(4));

    // Control: PC, FIFO pointers, fill flags and the inflight/drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            alloc_cnt    <= '0;
            inflight_cnt <= '0;
            drop_cnt     <= '0;
            filled       <= '0;
        end else if (bus.Redirect) begin
            // Every response still outstanding now belongs to the abandoned stream.
            pc           <= redirect_pc;
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            alloc_cnt    <= '0;
            inflight_cnt <= inflight_cnt - cnt_t'(rsp);
            drop_cnt     <= inflight_cnt - cnt_t'(rsp);
            filled       <= '0;
        end else begin
            if (grant) begin
                pc             <= pc + ADDRESS_WIDTH'(4);
                wr_ptr         <= wr_ptr + ptr_t'(1);
                filled[wr_ptr] <= 1'b0;
            end
            if (fill) begin
                fill_ptr         <= fill_ptr + ptr_t'(1);
                filled[fill_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            alloc_cnt    <= alloc_cnt + cnt_t'(grant) - cnt_t'(pop);
            inflight_cnt <= inflight_cnt + cnt_t'(grant) - cnt_t'(rsp);
            drop_cnt     <= drop_cnt - cnt_t'(rsp_drop);
        end
    end

    // Buffer storage: PC captured at grant, instruction word captured at fill.
    always_ff @(posedge clk) begin
        if (grant) begin
            pc_mem[wr_ptr] <= pc;
        end
        if (fill) begin
            data_mem[fill_ptr] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters of empty decode cycles and redirect cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            FetchBubbles  <= '0;
            RedirectCount <= '0;
        end else begin
            if (!head_valid && (FetchBubbles != 32'hFFFF_FFFF)) begin
                FetchBubbles <= FetchBubbles + 32'd1;
            end
            if (bus.Redirect && (RedirectCount != 32'hFFFF_FFFF)) begin
                RedirectCount <= RedirectCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (FIFO_DEPTH = 2). A memory model answers grants
// one cycle later; expected (PC, word) pairs are queued by each test and popped
// by a monitor whenever decode accepts an instruction.
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    logic rv_en;    // memory model may return responses
    logic inj_rv;   // force a spurious rvalid with nothing outstanding

    int n_cmp;
    int n_fail;

    logic [63:0] exp_q[$];   // {pc, instr}
    logic [31:0] pend_q[$];  // granted addresses awaiting a response

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_bubbles;
    logic [31:0] redirect_count;
`endif

    fetch_ctrl_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    fetch_ctrl #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .RESET_PC     (32'h0),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_EN
        ,
        .FetchBubbles (fetch_bubbles),
        .RedirectCount(redirect_count)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return (addr * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        exp_q.push_back({pc, instr_of(pc)});
    endtask

    // Memory model: record grants at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
        end else if (bus.imem_req && bus.imem_gnt) begin
            pend_q.push_back(bus.imem_addr);
        end
    end

    // Memory model: answer one cycle after the grant when allowed.
    always begin
        @(posedge clk);
        #2;
        if (inj_rv) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end else if (rv_en && !rst && pend_q.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(pend_q.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
    end

    // Monitor: every accepted instruction is checked against the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.InstrValid && bus.InstrReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_instr: got pc 0x%08h with no expected entry", bus.InstrPC);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("mon_instr_pc", bus.InstrPC, e[63:32]);
                check("mon_instr", bus.Instr, e[31:0]);
                check("mon_pc_plus4", bus.PCPlus4, e[63:32] + 32'd4);
            end
        end
    end

    // Driver: two reset cycles, optionally with spurious rvalid and checks.
    task automatic do_reset(input bit with_checks);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rst            = 1'b1;
            bus.Redirect   = 1'b0;
            bus.RedirectPC = '0;
            bus.imem_gnt   = 1'b0;
            bus.InstrReady = 1'b0;
            rv_en          = 1'b0;
            inj_rv         = with_checks;
            @(negedge clk);
            if (with_checks) begin
                check("rst_req", 32'(bus.imem_req), 32'd0);
                check("rst_valid", 32'(bus.InstrValid), 32'd0);
            end
        end
    endtask

    // Driver: one cycle of stimulus, returns at the falling edge for checks.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt,
                        input bit rv, input bit ready);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        inj_rv         = 1'b0;
        bus.Redirect   = redir;
        bus.RedirectPC = rpc;
        bus.imem_gnt   = gnt;
        bus.InstrReady = ready;
        rv_en          = rv;
        @(negedge clk);
    endtask

    initial begin
        n_cmp          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        rv_en          = 1'b0;
        inj_rv         = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPC = '0;
        bus.imem_gnt   = 1'b0;
        bus.InstrReady = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset, then streaming with grant always and immediate responses.
        do_reset(1'b1);
        expect_instr(32'h0);
        expect_instr(32'h4);
        expect_instr(32'h8);
        step(0, 0, 1, 1, 1);
        check("t1_req", 32'(bus.imem_req), 32'd1);
        check("t1_addr", bus.imem_addr, 32'h0);
        check("t1_valid", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 1, 1, 1);
        check("t2_req_c1", 32'(bus.imem_req), 32'd1);
        check("t2_addr_c1", bus.imem_addr, 32'h4);
        step(0, 0, 1, 1, 1);
        check("t2_valid_c2", 32'(bus.InstrValid), 32'd1);
        check("t2_pc_c2", bus.InstrPC, 32'h0);
        check("t2_pc4_c2", bus.PCPlus4, 32'h4);
        step(0, 0, 1, 1, 1);
        check("t2_valid_c3", 32'(bus.InstrValid), 32'd1);
        check("t2_pc_c3", bus.InstrPC, 32'h4);
        check("t2_pc4_c3", bus.PCPlus4, 32'h8);
        check("t2_addr_c3", bus.imem_addr, 32'h8);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: buffer fills, request stops, one pop reopens it.
        do_reset(1'b0);
        expect_instr(32'h0);
        expect_instr(32'h4);
        expect_instr(32'h8);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        check("t3_req_full", 32'(bus.imem_req), 32'd0);
        step(0, 0, 1, 1, 0);
        check("t3_req_held", 32'(bus.imem_req), 32'd0);
        check("t3_valid_held", 32'(bus.InstrValid), 32'd1);
        check("t3_pc_held", bus.InstrPC, 32'h0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 0);
        check("t3_req_resume", 32'(bus.imem_req), 32'd1);
        check("t3_addr_resume", bus.imem_addr, 32'h8);
        check("t3_pc_next", bus.InstrPC, 32'h4);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Redirect with two responses in flight: both dropped.
        do_reset(1'b0);
        expect_instr(32'h100);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h100, 0, 0, 1);
        check("t4_req_redir", 32'(bus.imem_req), 32'd0);
        check("t4_valid_redir", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t4_req_blocked", 32'(bus.imem_req), 32'd0);
        check("t4_valid_drop1", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t4_valid_drop2", 32'(bus.InstrValid), 32'd0);
        check("t4_req_new", 32'(bus.imem_req), 32'd1);
        check("t4_addr_new", bus.imem_addr, 32'h100);
        step(0, 0, 1, 1, 1);
        check("t4_addr_stable", bus.imem_addr, 32'h100);
        check("t4_valid_c5", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t4_valid_c6", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t4_valid_c7", 32'(bus.InstrValid), 32'd1);
        check("t4_pc_c7", bus.InstrPC, 32'h100);
        step(0, 0, 0, 1, 1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Redirect to an unaligned target in the same cycle as a response.
        do_reset(1'b0);
        expect_instr(32'h100);
        step(0, 0, 1, 1, 1);
        step(1, 32'h103, 1, 1, 1);
        check("t5_req_redir", 32'(bus.imem_req), 32'd0);
        check("t5_valid_redir", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 1, 1, 1);
        check("t5_req_new", 32'(bus.imem_req), 32'd1);
        check("t5_addr_new", bus.imem_addr, 32'h100);
        check("t5_valid_c2", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t5_valid_c3", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        check("t5_valid_c4", 32'(bus.InstrValid), 32'd1);
        check("t5_pc_c4", bus.InstrPC, 32'h100);
        step(0, 0, 0, 1, 1);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back redirects: last target wins, stale responses all dropped.
        do_reset(1'b0);
        expect_instr(32'h200);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h100, 0, 0, 1);
        step(1, 32'h200, 0, 1, 1);
        check("t7_valid_c3", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 1, 1, 1);
        check("t7_req", 32'(bus.imem_req), 32'd1);
        check("t7_addr", bus.imem_addr, 32'h200);
        check("t7_valid_c4", 32'(bus.InstrValid), 32'd0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t7_valid_c6", 32'(bus.InstrValid), 32'd1);
        check("t7_pc_c6", bus.InstrPC, 32'h200);
        step(0, 0, 0, 1, 1);
        check("t7_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_PERF_EN
        // Performance counters: three single-cycle redirects, no instructions.
        do_reset(1'b0);
        check("t6_rc_rst", redirect_count, 32'd0);
        check("t6_fb_rst", fetch_bubbles, 32'd0);
        for (int i = 0; i < 6; i++) step((i % 2) == 0, 32'h200, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t6_redirect_count", redirect_count, 32'd3);
        check("t6_fetch_bubbles", fetch_bubbles, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
